// File: rtl/color_bbox_extractor_if.sv
// Pixel-stream and per-frame result bundle for color_bbox_extractor.
// master = pixel source / result reader, slave = the extractor.
interface color_bbox_extractor_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic [7:0]  red_in;
  logic [7:0]  green_in;
  logic [7:0]  blue_in;
  logic [10:0] x_min_out;
  logic [10:0] x_max_out;
  logic [9:0]  y_min_out;
  logic [9:0]  y_max_out;
  logic        found_out;
  logic        valid_out;
  logic [20:0] pixel_count_out;

  modport master (
    output hcount_in, vcount_in, data_valid_in, red_in, green_in, blue_in,
    input  x_min_out, x_max_out, y_min_out, y_max_out, found_out, valid_out, pixel_count_out
  );

  modport slave (
    input  hcount_in, vcount_in, data_valid_in, red_in, green_in, blue_in,
    output x_min_out, x_max_out, y_min_out, y_max_out, found_out, valid_out, pixel_count_out
  );
endinterface

// File: rtl/color_bbox_extractor.sv
// Recovers the bounding box of target-coloured pixels in a raster stream, one result per frame.
// Define BBOX_AREA_EN for the matched-pixel counter, pixel_count_out and the MIN_PIXELS threshold.
//   state    | meaning
//   WAIT_SOF | after reset, waiting for a valid pixel at (0,0)
//   ACCUM    | folding stage-1 matches into the accumulators
//   PUBLISH  | one cycle: load outputs, strobe valid_out, restart accumulators
module color_bbox_extractor #(
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 720,
  parameter logic [23:0] TARGET_COLOR = 24'hFF_00_00,
  parameter logic [7:0]  TOLERANCE    = 8'd32,
  parameter int          MIN_PIXELS   = 16
) (
  input logic                   clk_in,
  input logic                   rst_in,
  color_bbox_extractor_if.slave pix
);

  localparam logic [1:0]  WAIT_SOF = 2'd0;
  localparam logic [1:0]  ACCUM    = 2'd1;
  localparam logic [1:0]  PUBLISH  = 2'd2;
  localparam logic [10:0] H_LIMIT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LIMIT  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [10:0] X_EMPTY  = '1;
  localparam logic [9:0]  Y_EMPTY  = '1;

  function automatic logic chan_ok(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] diff;
    diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return diff <= {1'b0, TOLERANCE};
  endfunction

  logic [1:0]  state_q, state_d;
  logic        s1_valid_q, s1_valid_d, s1_match_q, s1_match_d;
  logic [10:0] s1_h_q, s1_h_d;
  logic [9:0]  s1_v_q, s1_v_d;
  logic [10:0] acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
  logic [9:0]  acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
  logic [10:0] nxt_x_min, nxt_x_max;
  logic [9:0]  nxt_y_min, nxt_y_max;
  logic [10:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [9:0]  y_min_q, y_min_d, y_max_q, y_max_d;
  logic        found_q, found_d, valid_q, valid_d;
  logic        sof, eof, restart, acc_load, frame_found;
`ifdef BBOX_AREA_EN
  logic [20:0] acc_cnt_q, acc_cnt_d, nxt_cnt, pix_cnt_q, pix_cnt_d;
`endif

  always_comb begin
    s1_valid_d = pix.data_valid_in && (pix.hcount_in < H_LIMIT) && (pix.vcount_in < V_LIMIT);
    s1_match_d = s1_valid_d
                 && chan_ok(pix.red_in,   TARGET_COLOR[23:16])
                 && chan_ok(pix.green_in, TARGET_COLOR[15:8])
                 && chan_ok(pix.blue_in,  TARGET_COLOR[7:0]);
    s1_h_d     = pix.hcount_in;
    s1_v_d     = pix.vcount_in;
  end

  assign sof     = s1_valid_q && (s1_h_q == '0) && (s1_v_q == '0);
  assign eof     = s1_valid_q && (s1_h_q == H_LAST) && (s1_v_q == V_LAST);
  // A fresh (0,0) also restarts, so a frame whose last pixel was dropped is discarded.
  assign restart = (state_q == PUBLISH) || sof;

  always_comb begin
    nxt_x_min = restart ? X_EMPTY : acc_x_min_q;
    nxt_x_max = restart ? '0      : acc_x_max_q;
    nxt_y_min = restart ? Y_EMPTY : acc_y_min_q;
    nxt_y_max = restart ? '0      : acc_y_max_q;
`ifdef BBOX_AREA_EN
    nxt_cnt   = restart ? '0      : acc_cnt_q;
`endif
    if (s1_match_q) begin
      if (s1_h_q < nxt_x_min) nxt_x_min = s1_h_q;
      if (s1_h_q > nxt_x_max) nxt_x_max = s1_h_q;
      if (s1_v_q < nxt_y_min) nxt_y_min = s1_v_q;
      if (s1_v_q > nxt_y_max) nxt_y_max = s1_v_q;
`ifdef BBOX_AREA_EN
      if (nxt_cnt != '1) nxt_cnt = nxt_cnt + 21'd1;
`endif
    end
  end

`ifdef BBOX_AREA_EN
  assign frame_found = acc_cnt_q >= 21'(MIN_PIXELS);
`else
  assign frame_found = acc_x_max_q >= acc_x_min_q;
`endif

  always_comb begin
    state_d  = state_q;
    acc_load = 1'b0;
    valid_d  = 1'b0;
    found_d  = found_q;
    x_min_d  = x_min_q;
    x_max_d  = x_max_q;
    y_min_d  = y_min_q;
    y_max_d  = y_max_q;
`ifdef BBOX_AREA_EN
    pix_cnt_d = pix_cnt_q;
`endif
    case (state_q)
      WAIT_SOF: begin
        if (sof) begin
          acc_load = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_load = 1'b1;
        if (eof) state_d = PUBLISH;
      end
      PUBLISH: begin
        acc_load = 1'b1;
        valid_d  = 1'b1;
        found_d  = frame_found;
        if (frame_found) begin
          x_min_d = acc_x_min_q;
          x_max_d = acc_x_max_q;
          y_min_d = acc_y_min_q;
          y_max_d = acc_y_max_q;
        end
`ifdef BBOX_AREA_EN
        pix_cnt_d = acc_cnt_q;
`endif
        state_d = ACCUM;
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  always_comb begin
    acc_x_min_d = acc_load ? nxt_x_min : acc_x_min_q;
    acc_x_max_d = acc_load ? nxt_x_max : acc_x_max_q;
    acc_y_min_d = acc_load ? nxt_y_min : acc_y_min_q;
    acc_y_max_d = acc_load ? nxt_y_max : acc_y_max_q;
`ifdef BBOX_AREA_EN
    acc_cnt_d   = acc_load ? nxt_cnt   : acc_cnt_q;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= WAIT_SOF;
      s1_valid_q  <= 1'b0;
      s1_match_q  <= 1'b0;
      s1_h_q      <= '0;
      s1_v_q      <= '0;
      acc_x_min_q <= X_EMPTY;
      acc_x_max_q <= '0;
      acc_y_min_q <= Y_EMPTY;
      acc_y_max_q <= '0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
      found_q     <= 1'b0;
      valid_q     <= 1'b0;
`ifdef BBOX_AREA_EN
      acc_cnt_q   <= '0;
      pix_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_match_q  <= s1_match_d;
      s1_h_q      <= s1_h_d;
      s1_v_q      <= s1_v_d;
      acc_x_min_q <= acc_x_min_d;
      acc_x_max_q <= acc_x_max_d;
      acc_y_min_q <= acc_y_min_d;
      acc_y_max_q <= acc_y_max_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      y_min_q     <= y_min_d;
      y_max_q     <= y_max_d;
      found_q     <= found_d;
      valid_q     <= valid_d;
`ifdef BBOX_AREA_EN
      acc_cnt_q   <= acc_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
`endif
    end
  end

  assign pix.x_min_out = x_min_q;
  assign pix.x_max_out = x_max_q;
  assign pix.y_min_out = y_min_q;
  assign pix.y_max_out = y_max_q;
  assign pix.found_out = found_q;
  assign pix.valid_out = valid_q;
`ifdef BBOX_AREA_EN
  assign pix.pixel_count_out = pix_cnt_q;
`else
  assign pix.pixel_count_out = '0;
  // Without the counter the threshold has no meaning; keep the parameter referenced.
  if (MIN_PIXELS < 0) begin : g_min_pixels_unused
  end
`endif

endmodule

// File: tb/tb_color_bbox_extractor.sv
// Self-checking bench for color_bbox_extractor on a reduced 160x90 raster.
module tb_color_bbox_extractor;
  localparam int          H     = 160;
  localparam int          V     = 90;
  localparam int          MINP  = 16;
  localparam logic [23:0] TGT   = 24'hFF_00_00;
  localparam logic [23:0] BLACK = 24'h00_00_00;

  typedef struct {
    logic [23:0] rgb;
    int          x0, x1, y0, y1;
    bit          gap;
    int          exp_cnt;
  } vec_t;

  typedef struct {
    logic        found;
    logic [10:0] x_min, x_max;
    logic [9:0]  y_min, y_max;
    logic [20:0] cnt;
    int          cyc;
    int          id;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   unstable = 1'b0;
  exp_t sb[$];
  logic [10:0] m_x_min = '0, m_x_max = '0;
  logic [9:0]  m_y_min = '0, m_y_max = '0;
  vec_t vecs[6];

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  color_bbox_extractor_if bus ();

  color_bbox_extractor #(
    .H_ACTIVE(H), .V_ACTIVE(V), .TARGET_COLOR(TGT), .TOLERANCE(8'd32), .MIN_PIXELS(MINP)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .pix(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic put_px(input int x, input int y, input logic [23:0] rgb, input bit gap,
                        output int drv_cyc);
    @(posedge clk_in); #1;
    bus.hcount_in     = x[10:0];
    bus.vcount_in     = y[9:0];
    {bus.red_in, bus.green_in, bus.blue_in} = rgb;
    bus.data_valid_in = 1'b1;
    drv_cyc = cyc;
    if (gap) begin
      @(posedge clk_in); #1;
      bus.data_valid_in = 1'b0;
      {bus.red_in, bus.green_in, bus.blue_in} = TGT;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
      bus.data_valid_in = 1'b0;
    end
  endtask

  // Model: box holds its previous value unless the frame counts as found.
  task automatic expect_frame(input int id, input int cnt, input int x0, input int x1,
                              input int y0, input int y1, input int drv_cyc);
    exp_t e;
    logic f;
`ifdef BBOX_AREA_EN
    f = (cnt >= MINP);
    e.cnt = 21'(cnt);
`else
    f = (cnt > 0);
    e.cnt = '0;
`endif
    if (f) begin
      m_x_min = 11'(x0); m_x_max = 11'(x1);
      m_y_min = 10'(y0); m_y_max = 10'(y1);
    end
    e.found = f;
    e.x_min = m_x_min; e.x_max = m_x_max;
    e.y_min = m_y_min; e.y_max = m_y_max;
    e.cyc   = drv_cyc + 3;
    e.id    = id;
    sb.push_back(e);
  endtask

  task automatic run_vec(input int id, input vec_t t);
    int dc;
    put_px(0, 0, BLACK, t.gap, dc);
    for (int y = t.y0 - 1; y <= t.y1 + 1; y++) begin
      for (int x = t.x0 - 1; x <= t.x1 + 1; x++) begin
        if (x < 0 || y < 0 || x >= H || y >= V) continue;
        if ((x == 0 && y == 0) || (x == H - 1 && y == V - 1)) continue;
        put_px(x, y, (x >= t.x0 && x <= t.x1 && y >= t.y0 && y <= t.y1) ? t.rgb : BLACK,
               t.gap, dc);
      end
    end
    put_px(H - 1, V - 1, BLACK, t.gap, dc);
    expect_frame(id, t.exp_cnt, t.x0, t.x1, t.y0, t.y1, dc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x_min"}, 32'(bus.x_min_out), 0);
    check({tag, "_x_max"}, 32'(bus.x_max_out), 0);
    check({tag, "_y_min"}, 32'(bus.y_min_out), 0);
    check({tag, "_y_max"}, 32'(bus.y_max_out), 0);
    check({tag, "_found"}, 32'(bus.found_out), 0);
    check({tag, "_valid"}, 32'(bus.valid_out), 0);
    check({tag, "_count"}, 32'(bus.pixel_count_out), 0);
  endtask

  // Result monitor: pops the scoreboard on every strobe, watches outputs between strobes.
  initial begin
    exp_t        e;
    logic        pv;
    logic [63:0] snap, outs;
    pv = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk_in);
      outs = {bus.found_out, bus.x_min_out, bus.x_max_out, bus.y_min_out, bus.y_max_out,
              bus.pixel_count_out};
      if (!rst_in) begin
        snap = '0;
      end else if (bus.valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("f%0d_latency", e.id), cyc, e.cyc);
          check($sformatf("f%0d_pulse",   e.id), 32'(pv), 0);
          check($sformatf("f%0d_found",   e.id), 32'(bus.found_out), 32'(e.found));
          check($sformatf("f%0d_x_min",   e.id), 32'(bus.x_min_out), 32'(e.x_min));
          check($sformatf("f%0d_x_max",   e.id), 32'(bus.x_max_out), 32'(e.x_max));
          check($sformatf("f%0d_y_min",   e.id), 32'(bus.y_min_out), 32'(e.y_min));
          check($sformatf("f%0d_y_max",   e.id), 32'(bus.y_max_out), 32'(e.y_max));
          check($sformatf("f%0d_count",   e.id), 32'(bus.pixel_count_out), 32'(e.cnt));
        end
        snap = outs;
      end else if (outs != snap) begin
        unstable = 1'b1;
      end
      pv = bus.valid_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected it to end");
    $fatal(1);
  end

  initial begin
    int dc;
    vecs[0] = '{TGT,          100, 119, 50, 59, 1'b0, 200};
    vecs[1] = '{24'hE0_20_20,  10,  13,  5,  8, 1'b0,  16};
    vecs[2] = '{24'hDE_00_00,  20,  29, 20, 29, 1'b0,   0};
    vecs[3] = '{24'hDF_00_00,  30,  33, 30, 33, 1'b0,  16};
    vecs[4] = '{TGT,          100, 119, 50, 59, 1'b1, 200};
    vecs[5] = '{TGT,           40,  42, 60, 60, 1'b0,   3};

    bus.hcount_in = '0; bus.vcount_in = '0; bus.data_valid_in = 1'b0;
    bus.red_in = '0; bus.green_in = '0; bus.blue_in = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_zero("reset");
    rst_in = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Corners only, starting on the cycle right after the previous frame's last pixel.
    put_px(0, 0, TGT, 1'b0, dc);
    put_px(H, 10, TGT, 1'b0, dc);
    put_px(H + 3, 10, TGT, 1'b0, dc);
    put_px(50, V, TGT, 1'b0, dc);
    for (int x = 50; x < 64; x++) put_px(x, 40, TGT, 1'b0, dc);
    put_px(H - 1, V - 1, TGT, 1'b0, dc);
    expect_frame(6, 16, 0, H - 1, 0, V - 1, dc);
    idle(6);

    // Partial frame abandoned without its last pixel, then a complete one.
    put_px(0, 0, BLACK, 1'b0, dc);
    for (int x = 0; x < 20; x++) put_px(x, 3, TGT, 1'b0, dc);
    run_vec(7, '{TGT, 70, 73, 20, 23, 1'b0, 16});
    idle(6);

    // Reset mid-frame: the rest of that frame must never publish.
    put_px(0, 0, BLACK, 1'b0, dc);
    for (int x = 5; x < 10; x++) put_px(x, 5, TGT, 1'b0, dc);
    rst_in = 1'b0;
    for (int x = 10; x < 14; x++) put_px(x, 5, TGT, 1'b0, dc);
    @(negedge clk_in);
    check_zero("midrst");
    m_x_min = '0; m_x_max = '0; m_y_min = '0; m_y_max = '0;
    rst_in = 1'b1;
    for (int x = 14; x < 31; x++) put_px(x, 5, TGT, 1'b0, dc);
    put_px(H - 1, V - 1, TGT, 1'b0, dc);
    idle(6);
    run_vec(8, '{TGT, 120, 123, 80, 83, 1'b0, 16});
    idle(8);

    check("scoreboard_drained", sb.size(), 0);
    check("outputs_stable", 32'(unstable), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
